// File: rtl/traffic_sensor_lamp_if.sv
// Field-side interface for a 2-bit traffic-light FSM: conditions raw detectors into ta/tb
// hold requests with min/max green enforcement, and decodes y into registered lamp drives.
module traffic_sensor_lamp_if #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned MIN_GREEN  = 8,
    parameter int unsigned MAX_GREEN  = 32
) (
    input  logic       clk,
    input  logic       r,
    input  logic       sa,
    input  logic       sb,
    input  logic [1:0] y,
    output logic       ta,
    output logic       tb,
    output logic [2:0] la,
    output logic [2:0] lb
);

    localparam int unsigned DW = (MAX_GREEN > 1) ? $clog2(MAX_GREEN) : 1;
    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_MAX = DW'(MAX_GREEN - 1);
    localparam logic [DW-1:0] MIN_LIM   = DW'(MIN_GREEN - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEB_CYCLES - 1);

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    // Index 0 is street A, index 1 is street B.
    logic [1:0]    r_meta;
    logic [1:0]    r_sync;
    logic [1:0]    r_deb;
    logic [CW-1:0] r_cnt [2];

    logic [1:0]    r_y_q;
    logic [DW-1:0] r_dwell;
    logic [2:0]    r_la;
    logic [2:0]    r_lb;

    logic [DW-1:0] w_dwell_eff;
    logic [DW-1:0] w_dwell_nxt;
    logic          w_min_hold;
    logic          w_at_max;
    logic          w_ta;
    logic          w_tb;

    always_ff @(posedge clk) begin
        if (r) begin
            r_meta   <= '0;
            r_sync   <= '0;
            r_deb    <= '0;
            r_cnt[0] <= '0;
            r_cnt[1] <= '0;
        end else begin
            r_meta <= {sb, sa};
            r_sync <= r_meta;
            // Count only while the synchronised input disagrees; any agreeing cycle restarts it.
            for (int i = 0; i < 2; i++) begin
                if (r_sync[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_deb[i] <= ~r_deb[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_dwell_eff = (y != r_y_q) ? '0 : r_dwell;
        w_dwell_nxt = (w_dwell_eff == DWELL_MAX) ? w_dwell_eff : w_dwell_eff + 1'b1;
        w_min_hold  = (w_dwell_eff < MIN_LIM);
        w_at_max    = (w_dwell_eff >= DWELL_MAX);
    end

    always_ff @(posedge clk) begin
        if (r) begin
            r_y_q   <= 2'b00;
            r_dwell <= '0;
        end else begin
            r_y_q   <= y;
            r_dwell <= w_dwell_nxt;
        end
    end

    // A waiting cross street pre-empts own traffic once the green hits its limit.
    always_comb begin
        w_ta = r_deb[0];
        w_tb = r_deb[1];
        if (y == 2'b00) begin
            w_ta = w_min_hold | (r_deb[0] & ~(r_deb[1] & w_at_max));
        end else if (y == 2'b10) begin
            w_tb = w_min_hold | (r_deb[1] & ~(r_deb[0] & w_at_max));
        end
    end

    always_ff @(posedge clk) begin
        if (r) begin
            r_la <= LAMP_RED;
            r_lb <= LAMP_RED;
        end else begin
            unique case (y)
                2'b00: begin r_la <= LAMP_GREEN;  r_lb <= LAMP_RED;    end
                2'b01: begin r_la <= LAMP_YELLOW; r_lb <= LAMP_RED;    end
                2'b10: begin r_la <= LAMP_RED;    r_lb <= LAMP_GREEN;  end
                2'b11: begin r_la <= LAMP_RED;    r_lb <= LAMP_YELLOW; end
            endcase
        end
    end

    assign ta = w_ta;
    assign tb = w_tb;
    assign la = r_la;
    assign lb = r_lb;

endmodule

// File: tb/tb_traffic_sensor_lamp_if.sv
// Directed bench for traffic_sensor_lamp_if: lamp/request table plus hand-written
// debounce, min/max green and mid-operation reset sequences.
module tb_traffic_sensor_lamp_if;

    logic       clk;
    logic       r;
    logic       sa;
    logic       sb;
    logic [1:0] y;
    logic       ta;
    logic       tb;
    logic [2:0] la;
    logic [2:0] lb;

    int n_pass;
    int n_total;

    typedef struct packed {
        logic [1:0] y;
        logic       ta;
        logic       tb;
        logic [2:0] la;
        logic [2:0] lb;
    } vec_t;

    vec_t vecs [5];

    traffic_sensor_lamp_if #(
        .DEB_CYCLES(4),
        .MIN_GREEN (8),
        .MAX_GREEN (32)
    ) dut (
        .clk(clk),
        .r  (r),
        .sa (sa),
        .sb (sb),
        .y  (y),
        .ta (ta),
        .tb (tb),
        .la (la),
        .lb (lb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        // Lamp decode and zero-dwell request values with deb_a = deb_b = 0.
        vecs[0] = '{y: 2'b00, ta: 1'b1, tb: 1'b0, la: 3'b001, lb: 3'b100};
        vecs[1] = '{y: 2'b01, ta: 1'b0, tb: 1'b0, la: 3'b010, lb: 3'b100};
        vecs[2] = '{y: 2'b10, ta: 1'b0, tb: 1'b1, la: 3'b100, lb: 3'b001};
        vecs[3] = '{y: 2'b11, ta: 1'b0, tb: 1'b0, la: 3'b100, lb: 3'b010};
        vecs[4] = '{y: 2'b00, ta: 1'b1, tb: 1'b0, la: 3'b001, lb: 3'b100};

        r = 1'b1; y = 2'b00; sa = 1'b0; sb = 1'b0;

        // Reset for two cycles, then release.
        tick();
        chk("rst_la", la, 3'b100);
        chk("rst_lb", lb, 3'b100);
        chk("rst_ta", ta, 1'b1);
        chk("rst_tb", tb, 1'b0);
        tick();
        chk("rst2_la", la, 3'b100);
        r = 1'b0;
        tick();
        chk("post_rst_la", la, 3'b001);
        chk("post_rst_lb", lb, 3'b100);

        // Short pulse on sa must be rejected; a held level appears 6 cycles later.
        y = 2'b01;
        tick();
        chk("y01_ta_idle", ta, 1'b0);
        sa = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("pulse_hi_ta", ta, 1'b0);
        end
        sa = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("pulse_lo_ta", ta, 1'b0);
        end
        sa = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("deb_rise_ta", ta, (k == 6));
        end
        sa = 1'b0;
        repeat (6) tick();
        chk("deb_fall_ta", ta, 1'b0);

        // Minimum green with no traffic.
        y = 2'b00;
        #1;
        chk("min_ta_k0", ta, 1'b1);
        chk("min_tb_k0", tb, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("min_ta", ta, (k < 7));
        end

        // Maximum green with both streets waiting, then release of B.
        y = 2'b01; sa = 1'b1; sb = 1'b1;
        repeat (7) tick();
        chk("both_deb_ta", ta, 1'b1);
        chk("both_deb_tb", tb, 1'b1);
        y = 2'b00;
        #1;
        for (int k = 0; k <= 32; k++) begin
            if (k > 0) tick();
            chk("max_ta", ta, (k < 31));
        end
        sb = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("sat_ta", ta, (k >= 6));
            chk("sat_tb", tb, (k < 6));
        end

        // Lamp / request decode table, one y value per cycle.
        sa = 1'b0; y = 2'b01;
        repeat (7) tick();
        for (int i = 0; i < 5; i++) begin
            y = vecs[i].y;
            #1;
            chk("tbl_ta", ta, vecs[i].ta);
            chk("tbl_tb", tb, vecs[i].tb);
            tick();
            chk("tbl_la", la, vecs[i].la);
            chk("tbl_lb", lb, vecs[i].lb);
        end

        // Reset in the middle of a B green with an A debounce count in flight.
        y = 2'b10; sa = 1'b1;
        repeat (5) tick();
        chk("pre_rst_ta", ta, 1'b0);
        chk("pre_rst_tb", tb, 1'b1);
        r = 1'b1;
        tick();
        chk("mid_rst_la", la, 3'b100);
        chk("mid_rst_lb", lb, 3'b100);
        chk("mid_rst_ta", ta, 1'b0);
        chk("mid_rst_tb", tb, 1'b1);
        r = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("rst_deb_ta", ta, (k >= 6));
            chk("rst_dwell_tb", tb, (k < 7));
            if (k == 1) begin
                chk("rst_rel_la", la, 3'b100);
                chk("rst_rel_lb", lb, 3'b001);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
